dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core LSU (port A)
// and a debug/DMA master (port B). Reads take one cycle from grant to data.
// Partial-byte writes are done as read-modify-write, because the memory has no
// byte enables. Accesses beyond MEM_WORDS never reach the memory. They complete
// with an error and 32'hDEADBEEF as the data.
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking. By default
// the arbiter uses fixed priority, A over B.

module dmem_arbiter #(
   parameter int MEM_WORDS = 4096
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        a_req_i,
   input  logic        b_req_i,
   input  logic        a_we_i,
   input  logic        b_we_i,
   input  logic [3:0]  a_be_i,
   input  logic [3:0]  b_be_i,
   input  logic [31:0] a_addr_i,
   input  logic [31:0] b_addr_i,
   input  logic [31:0] a_wdata_i,
   input  logic [31:0] b_wdata_i,
   output logic        a_gnt_o,
   output logic        b_gnt_o,
   output logic        a_rvalid_o,
   output logic        b_rvalid_o,
   output logic [31:0] a_rdata_o,
   output logic [31:0] b_rdata_o,
   output logic        a_err_o,
   output logic        b_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      MERGE = 2'd2,
      ACK   = 2'd3
   } state_t;

   localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;
   localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

   state_t      state_q;
   state_t      state_d;

   // Transaction owner (0 = A, 1 = B) and the fields needed after the grant cycle
   logic        owner_q;
   logic [29:0] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic        err_q;

   logic        grant_a;
   logic        grant_b;
   logic        grant_any;

   logic        sel_we;
   logic [3:0]  sel_be;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [31:0] sel_word_addr;
   logic        sel_oor;
   logic        unused_byte_offset;

   logic [31:0] merged_word;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;

`ifdef DMEM_ARB_RR_EN
   // Set when B received the most recent grant. It resets to 1 so that A wins the first tie.
   logic        last_b_q;
`endif

   // Decide who is granted this cycle; grants exist only in IDLE and never during reset
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state_q == IDLE && !rst_i) begin
         if (a_req_i && b_req_i) begin
`ifdef DMEM_ARB_RR_EN
            grant_a = last_b_q;
            grant_b = !last_b_q;
`else
            grant_a = 1'b1;
`endif
         end else begin
            grant_a = a_req_i;
            grant_b = b_req_i;
         end
      end
   end

   assign grant_any = grant_a || grant_b;

   // Steer the winning requester's fields onto a common set of signals
   always_comb begin
      if (grant_b) begin
         sel_we    = b_we_i;
         sel_be    = b_be_i;
         sel_addr  = b_addr_i;
         sel_wdata = b_wdata_i;
      end else begin
         sel_we    = a_we_i;
         sel_be    = a_be_i;
         sel_addr  = a_addr_i;
         sel_wdata = a_wdata_i;
      end
   end

   assign sel_word_addr      = {2'b00, sel_addr[31:2]};
   assign sel_oor            = (sel_word_addr >= MEM_LIMIT);
   assign unused_byte_offset = ^sel_addr[1:0];

   // Combine enabled bytes from the write data with the current memory contents for read-modify-write
   always_comb begin
      merged_word = mem_rdata_i;
      for (int i = 0; i < 4; i++) begin
         if (be_q[i]) begin
            merged_word[8*i +: 8] = wdata_q[8*i +: 8];
         end
      end
   end

   // State register; reset forces IDLE at once, which abandons any transaction in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection by transaction type
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               if (sel_oor) begin
                  state_d = ACK;
               end else if (!sel_we) begin
                  state_d = READ;
               end else if (sel_be == 4'b1111 || sel_be == 4'b0000) begin
                  state_d = ACK;
               end else begin
                  state_d = MERGE;
               end
            end
         end
         READ:    state_d = IDLE;
         MERGE:   state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture the accepted request so later states can finish it after the requester moves on
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner_q <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else if (grant_any) begin
         owner_q <= grant_b;
         addr_q  <= sel_addr[31:2];
         be_q    <= sel_be;
         wdata_q <= sel_wdata;
         err_q   <= sel_oor;
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Remember which side received the most recent grant, for fair tie breaking
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_b_q <= 1'b1;
      end else if (grant_any) begin
         last_b_q <= grant_b;
      end
   end
`endif

   // Drive the memory port and the response for the current state, then route the response to the owner
   always_comb begin
      a_gnt_o     = grant_a;
      b_gnt_o     = grant_b;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      resp_valid  = 1'b0;
      resp_data   = '0;
      resp_err    = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_any && !sel_oor) begin
               if (!sel_we) begin
                  mem_req_o  = 1'b1;
                  mem_addr_o = sel_word_addr;
               end else if (sel_be == 4'b1111) begin
                  mem_req_o   = 1'b1;
                  mem_we_o    = 1'b1;
                  mem_addr_o  = sel_word_addr;
                  mem_wdata_o = sel_wdata;
               end else if (sel_be != 4'b0000) begin
                  mem_req_o  = 1'b1;
                  mem_addr_o = sel_word_addr;
               end
            end
         end
         READ: begin
            resp_valid = 1'b1;
            resp_data  = mem_rdata_i;
         end
         MERGE: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {2'b00, addr_q};
            mem_wdata_o = merged_word;
         end
         ACK: begin
            resp_valid = 1'b1;
            resp_data  = err_q ? ERR_DATA : 32'h0;
            resp_err   = err_q;
         end
         default: begin
            resp_valid = 1'b0;
         end
      endcase
      a_rvalid_o = resp_valid && !owner_q;
      b_rvalid_o = resp_valid && owner_q;
      a_rdata_o  = owner_q ? 32'h0 : resp_data;
      b_rdata_o  = owner_q ? resp_data : 32'h0;
      a_err_o    = resp_err && !owner_q;
      b_err_o    = resp_err && owner_q;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a 4096-word memory model
// that has one cycle of read latency. Expected arbitration order follows DMEM_ARB_RR_EN.

module tb_dmem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        a_req_i, b_req_i, a_we_i, b_we_i;
   logic [3:0]  a_be_i, b_be_i;
   logic [31:0] a_addr_i, b_addr_i, a_wdata_i, b_wdata_i;
   logic        a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, a_err_o, b_err_o;
   logic [31:0] a_rdata_o, b_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

   int          checks = 0;
   int          failures = 0;
   int          mem_access_count = 0;
   int          mem_write_count = 0;
   logic [31:0] mem [0:4095];

   dmem_arbiter #(.MEM_WORDS(4096)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .a_req_i(a_req_i), .b_req_i(b_req_i),
      .a_we_i(a_we_i), .b_we_i(b_we_i),
      .a_be_i(a_be_i), .b_be_i(b_be_i),
      .a_addr_i(a_addr_i), .b_addr_i(b_addr_i),
      .a_wdata_i(a_wdata_i), .b_wdata_i(b_wdata_i),
      .a_gnt_o(a_gnt_o), .b_gnt_o(b_gnt_o),
      .a_rvalid_o(a_rvalid_o), .b_rvalid_o(b_rvalid_o),
      .a_rdata_o(a_rdata_o), .b_rdata_o(b_rdata_o),
      .a_err_o(a_err_o), .b_err_o(b_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // Single-port memory model: 1-cycle read latency, whole-word writes, access counters
   always @(posedge clk_i) begin
      if (mem_req_o) begin
         mem_access_count <= mem_access_count + 1;
         if (mem_we_o) begin
            mem_write_count <= mem_write_count + 1;
            if (mem_addr_o < 32'd4096) mem[mem_addr_o[11:0]] <= mem_wdata_o;
         end else begin
            mem_rdata_i <= (mem_addr_o < 32'd4096) ? mem[mem_addr_o[11:0]] : 32'hX;
         end
      end
   end

   // Hard stop in case something wedges the sequence
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit side_b, input bit req, input bit we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (side_b) begin
         b_req_i = req; b_we_i = we; b_be_i = be; b_addr_i = addr; b_wdata_i = wdata;
      end else begin
         a_req_i = req; a_we_i = we; a_be_i = be; a_addr_i = addr; a_wdata_i = wdata;
      end
   endtask

   // Issue one transaction, called and returning at posedge+1; waits are bounded
   task automatic runTxn(input bit side_b, input bit we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, output int gnt_wait, output int latency,
                         output logic [31:0] rdata, output logic err, output logic other_valid);
      applyStimulus(side_b, 1'b1, we, be, addr, wdata);
      gnt_wait = 0;
      #2;
      while (!(side_b ? b_gnt_o : a_gnt_o) && gnt_wait < 20) begin
         @(posedge clk_i); #3;
         gnt_wait++;
      end
      @(posedge clk_i); #1;
      applyStimulus(side_b, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #2;
      latency = 1;
      while (!(side_b ? b_rvalid_o : a_rvalid_o) && latency < 20) begin
         @(posedge clk_i); #3;
         latency++;
      end
      rdata       = side_b ? b_rdata_o : a_rdata_o;
      err         = side_b ? b_err_o : a_err_o;
      other_valid = side_b ? a_rvalid_o : b_rvalid_o;
      @(posedge clk_i); #1;
   endtask

   initial begin
      int          gw, lat, base_acc, base_wr;
      logic [31:0] rd;
      logic        er, ov;
      logic [1:0]  arb_exp [4];
      logic [1:0]  exp_gnt;

`ifdef DMEM_ARB_RR_EN
      arb_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
      arb_exp = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif

      // Reset with a request already pending: nothing may be granted or issued
      rst_i = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk_i);
      #1;
      applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      #2;
      checkOutput("rst_a_gnt", 32'(a_gnt_o), 32'h0);
      checkOutput("rst_mem_req", 32'(mem_req_o), 32'h0);
      checkOutput("rst_mem_we", 32'(mem_we_o), 32'h0);
      checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
      checkOutput("rst_a_rvalid", 32'(a_rvalid_o), 32'h0);
      checkOutput("rst_b_rdata", b_rdata_o, 32'h0);

      // Both sides read continuously straight out of reset; the first tie goes to A
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
      for (int i = 0; i < 8; i++) begin
         #2;
         exp_gnt = (i % 2 == 1) ? 2'b00 : arb_exp[i / 2];
         checkOutput($sformatf("arb_gnt_cycle%0d", i), 32'({a_gnt_o, b_gnt_o}), 32'(exp_gnt));
         @(posedge clk_i); #1;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(posedge clk_i); #1;

      // B full-word write preloads word 0x10 with 0x12345678
      runTxn(1'b1, 1'b1, 4'hF, 32'h40, 32'h12345678, gw, lat, rd, er, ov);
      checkOutput("b_wr_gnt_wait", 32'(gw), 32'd0);
      checkOutput("b_wr_latency", 32'(lat), 32'd1);
      checkOutput("b_wr_rdata", rd, 32'h0);
      checkOutput("b_wr_mem_word", mem[16], 32'h12345678);

      // A read of word 0x10: grant in cycle 0, data in cycle 1
      runTxn(1'b0, 1'b0, 4'h0, 32'h40, 32'h0, gw, lat, rd, er, ov);
      checkOutput("a_rd_gnt_wait", 32'(gw), 32'd0);
      checkOutput("a_rd_latency", 32'(lat), 32'd1);
      checkOutput("a_rd_rdata", rd, 32'h12345678);
      checkOutput("a_rd_err", 32'(er), 32'h0);
      checkOutput("a_rd_b_rvalid", 32'(ov), 32'h0);

      // Partial write 0x0000AB00 with be=0010 over 0x11223344 gives 0x1122AB44
      runTxn(1'b1, 1'b1, 4'hF, 32'h40, 32'h11223344, gw, lat, rd, er, ov);
      runTxn(1'b0, 1'b1, 4'b0010, 32'h40, 32'h0000AB00, gw, lat, rd, er, ov);
      checkOutput("merge_latency", 32'(lat), 32'd2);
      checkOutput("merge_rdata", rd, 32'h0);
      checkOutput("merge_mem_word", mem[16], 32'h1122AB44);
      runTxn(1'b0, 1'b0, 4'h0, 32'h43, 32'h0, gw, lat, rd, er, ov);
      checkOutput("merge_readback", rd, 32'h1122AB44);

      // Write with no byte enables must not touch memory
      base_acc = mem_access_count;
      runTxn(1'b0, 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, gw, lat, rd, er, ov);
      checkOutput("be0_latency", 32'(lat), 32'd1);
      checkOutput("be0_mem_accesses", 32'(mem_access_count - base_acc), 32'd0);
      checkOutput("be0_mem_word", mem[16], 32'h1122AB44);

      // Last in-range word is writable
      runTxn(1'b0, 1'b1, 4'hF, 32'h3FFC, 32'hCAFEF00D, gw, lat, rd, er, ov);
      checkOutput("last_word_err", 32'(er), 32'h0);
      checkOutput("last_word_mem", mem[4095], 32'hCAFEF00D);

      // B read of word 0x1000 is out of range: no memory access, error response
      base_acc = mem_access_count;
      runTxn(1'b1, 1'b0, 4'h0, 32'h4000, 32'h0, gw, lat, rd, er, ov);
      checkOutput("oor_mem_accesses", 32'(mem_access_count - base_acc), 32'd0);
      checkOutput("oor_latency", 32'(lat), 32'd1);
      checkOutput("oor_err", 32'(er), 32'h1);
      checkOutput("oor_rdata", rd, 32'hDEADBEEF);
      checkOutput("oor_a_rvalid", 32'(ov), 32'h0);

      // Reset during MERGE aborts the write; A is granted on the first edge after release
      base_wr = mem_write_count;
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, 32'h40, 32'h000000EE);
      #2;
      checkOutput("mrst_a_gnt", 32'(a_gnt_o), 32'h1);
      @(posedge clk_i); #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      checkOutput("mrst_in_merge_we", 32'(mem_we_o), 32'h1);
      rst_i = 1'b1;
      #1;
      checkOutput("mrst_mem_req", 32'(mem_req_o), 32'h0);
      checkOutput("mrst_a_rvalid", 32'(a_rvalid_o), 32'h0);
      @(posedge clk_i); #1;
      checkOutput("mrst_a_rvalid_held", 32'(a_rvalid_o), 32'h0);
      rst_i = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
      #2;
      checkOutput("mrst_release_gnt", 32'(a_gnt_o), 32'h1);
      @(posedge clk_i); #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #2;
      checkOutput("mrst_release_rvalid", 32'(a_rvalid_o), 32'h1);
      checkOutput("mrst_word_unchanged", a_rdata_o, 32'h1122AB44);
      checkOutput("mrst_no_mem_write", 32'(mem_write_count - base_wr), 32'd0);
      @(posedge clk_i); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
